// File: rtl/rca_seq_ctrl.sv
// Sequential adder/subtractor: one 4-bit ripple-carry slice reused per cycle, LSB nibble first.
// Valid/ready on both sides; the result is held in DONE until the consumer accepts it.
module rca_seq_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   A,
    input  logic [4*NIBBLES-1:0]   B,
    input  logic                   op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   S,
    output logic                   C,
    output logic                   V,
    output logic                   busy
);

    localparam int unsigned W    = 4 * NIBBLES;
    localparam int unsigned IdxW = $clog2(NIBBLES);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [W-1:0]      a_q, b_q, s_q;
    logic              op_q, carry_q, c_q, v_q;
    logic [IdxW-1:0]   idx_q;

    logic [3:0]        nib_a, nib_b, slice_sum;
    logic              cy, c_into_msb, c_out;
    logic              accept, last_nib;

    assign accept   = (state_q == StIdle) && in_valid;
    assign last_nib = (idx_q == IdxW'(NIBBLES - 1));

    // Single ripple slice; subtract inverts B and relies on carry_q starting at op.
    always_comb begin
        nib_a      = a_q[4*idx_q +: 4];
        nib_b      = b_q[4*idx_q +: 4] ^ {4{op_q}};
        slice_sum  = '0;
        c_into_msb = 1'b0;
        cy         = carry_q;
        for (int k = 0; k < 4; k++) begin
            slice_sum[k] = nib_a[k] ^ nib_b[k] ^ cy;
            if (k == 3) c_into_msb = cy;
            cy = (nib_a[k] & nib_b[k]) | (cy & (nib_a[k] ^ nib_b[k]));
        end
        c_out = cy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid)  state_d = StRun;
            StRun:   if (last_nib)  state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default:                state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 1'b0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
        end else if (accept) begin
            a_q     <= A;
            b_q     <= B;
            op_q    <= op;
            idx_q   <= '0;
            carry_q <= op;
        end else if (state_q == StRun) begin
            s_q[4*idx_q +: 4] <= slice_sum;
            carry_q           <= c_out;
            if (last_nib) begin
                c_q <= c_out;
                v_q <= c_into_msb ^ c_out;
            end else begin
                idx_q <= idx_q + IdxW'(1);
            end
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign S         = s_q;
    assign C         = c_q;
    assign V         = v_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed bench for rca_seq_ctrl (NIBBLES=4): arithmetic corners, backpressure, reset, streaming.
module tb_rca_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        op = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] S;
    logic        C, V, busy;

    int pass_cnt = 0;
    int total    = 0;
    int lat;

    rca_seq_ctrl #(.NIBBLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .S(S), .C(C), .V(V), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference arithmetic: 17-bit add of A and (B or ~B+1), sign rule for overflow.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic o);
        logic [16:0] full;
        logic        ov;
        if (o) full = {1'b0, a} + {1'b0, ~b} + 17'd1;
        else   full = {1'b0, a} + {1'b0, b};
        if (o) ov = (a[15] != b[15]) && (full[15] != a[15]);
        else   ov = (a[15] == b[15]) && (full[15] != a[15]);
        return {full[16], ov, full[15:0]};
    endfunction

    // Present a request on the accept edge, then scramble the inputs.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic o);
        A = a; B = b; op = o; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; A = ~a; B = ~b; op = ~o;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({in_ready, out_valid, busy, S, C, V} !== {1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0}) begin
            $display("FAIL reset_state: got rdy=%b vld=%b busy=%b S=%h C=%b V=%b, want 1 0 0 0000 0 0",
                     in_ready, out_valid, busy, S, C, V);
        end else pass_cnt++;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_add();
        start_op(16'h0001, 16'h0001, 1'b0);
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            $display("FAIL add_busy: busy=%b in_ready=%b, want 1 0", busy, in_ready);
        end else pass_cnt++;
        wait_done(lat);
        total++;
        if (lat !== 4) $display("FAIL add_latency: got %0d cycles, want 4", lat);
        else pass_cnt++;
        total++;
        if ({S, C, V} !== {16'h0002, 1'b0, 1'b0})
            $display("FAIL add_1_1: got S=%h C=%b V=%b, want 0002 0 0", S, C, V);
        else pass_cnt++;
        handshake();

        start_op(16'hFFFF, 16'h0001, 1'b0);
        wait_done(lat);
        total++;
        if ({S, C, V} !== {16'h0000, 1'b1, 1'b0} || lat !== 4)
            $display("FAIL add_ffff_1: got S=%h C=%b V=%b lat=%0d, want 0000 1 0 4", S, C, V, lat);
        else pass_cnt++;
        handshake();

        start_op(16'h7FFF, 16'h0001, 1'b0);
        wait_done(lat);
        total++;
        if ({S, C, V} !== {16'h8000, 1'b0, 1'b1})
            $display("FAIL add_7fff_1: got S=%h C=%b V=%b, want 8000 0 1", S, C, V);
        else pass_cnt++;
        handshake();
    endtask

    task automatic test_sub();
        start_op(16'h0005, 16'h0007, 1'b1);
        wait_done(lat);
        total++;
        if ({S, C, V} !== {16'hFFFE, 1'b0, 1'b0})
            $display("FAIL sub_5_7: got S=%h C=%b V=%b, want fffe 0 0", S, C, V);
        else pass_cnt++;
        handshake();

        start_op(16'h8000, 16'h0001, 1'b1);
        wait_done(lat);
        total++;
        if ({S, C, V} !== {16'h7FFF, 1'b1, 1'b1})
            $display("FAIL sub_8000_1: got S=%h C=%b V=%b, want 7fff 1 1", S, C, V);
        else pass_cnt++;
        handshake();
    endtask

    task automatic test_backpressure();
        start_op(16'h1111, 16'h2222, 1'b0);
        wait_done(lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; A = 16'hDEAD; B = 16'hBEEF; op = 1'b1;
            @(posedge clk); #1;
            total++;
            if ({out_valid, in_ready, busy, S, C, V} !==
                {1'b1, 1'b0, 1'b1, 16'h3333, 1'b0, 1'b0})
                $display("FAIL hold_%0d: got vld=%b rdy=%b busy=%b S=%h C=%b V=%b, want 1 0 1 3333 0 0",
                         i, out_valid, in_ready, busy, S, C, V);
            else pass_cnt++;
        end
        in_valid = 1'b0;
        handshake();
        total++;
        if ({out_valid, in_ready, busy, S} !== {1'b0, 1'b1, 1'b0, 16'h3333})
            $display("FAIL release_idle: got vld=%b rdy=%b busy=%b S=%h, want 0 1 0 3333",
                     out_valid, in_ready, busy, S);
        else pass_cnt++;

        start_op(16'h0F0F, 16'h0101, 1'b1);
        wait_done(lat);
        total++;
        if ({S, C, V} !== {16'h0E0E, 1'b1, 1'b0} || lat !== 4)
            $display("FAIL after_bp: got S=%h C=%b V=%b lat=%0d, want 0e0e 1 0 4", S, C, V, lat);
        else pass_cnt++;
        handshake();
    endtask

    task automatic test_reset_mid();
        start_op(16'hAAAA, 16'h5555, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        total++;
        if ({S, C, V, out_valid, busy, in_ready} !== {16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1})
            $display("FAIL reset_mid: got S=%h C=%b V=%b vld=%b busy=%b rdy=%b, want 0000 0 0 0 0 1",
                     S, C, V, out_valid, busy, in_ready);
        else pass_cnt++;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        start_op(16'h1234, 16'h4321, 1'b0);
        wait_done(lat);
        total++;
        if ({S, C} !== {16'h5555, 1'b0} || lat !== 4)
            $display("FAIL after_reset: got S=%h C=%b lat=%0d, want 5555 0 4", S, C, lat);
        else pass_cnt++;
        handshake();
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [4] = '{16'h1234, 16'h0001, 16'hFFFF, 16'h8000};
        logic [15:0] vb [4] = '{16'h0F0F, 16'h0002, 16'hFFFF, 16'h8000};
        logic        vo [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [17:0] expq [$];
        logic [17:0] e;
        int k = 0, got = 0, cyc = 0, last_t = 0;
        logic rdy;
        A = va[0]; B = vb[0]; op = vo[0]; in_valid = 1'b1; out_ready = 1'b1;
        while (got < 4 && cyc < 80) begin
            rdy = in_ready;
            @(posedge clk); #1;
            cyc++;
            if (rdy && k < 4) begin
                expq.push_back(model(va[k], vb[k], vo[k]));
                k++;
                if (k < 4) begin A = va[k]; B = vb[k]; op = vo[k]; end
                else in_valid = 1'b0;
            end
            if (out_valid) begin
                e = expq.pop_front();
                total++;
                if ({C, V, S} !== e)
                    $display("FAIL b2b_result_%0d: got C=%b V=%b S=%h, want C=%b V=%b S=%h",
                             got, C, V, S, e[17], e[16], e[15:0]);
                else pass_cnt++;
                if (got > 0) begin
                    total++;
                    if (cyc - last_t !== 6)
                        $display("FAIL b2b_interval_%0d: got %0d cycles, want 6", got, cyc - last_t);
                    else pass_cnt++;
                end
                last_t = cyc;
                got++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        total++;
        if (got !== 4) $display("FAIL b2b_count: got %0d results, want 4", got);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
